// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the EX stage.
// Multiplies use shift-add and divides use restoring division, both on operand
// magnitudes. The sign is fixed up in the same cycle the result is written.
// Divide-by-zero and signed overflow finish in one cycle without iterating.
module rv_muldiv_unit #(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      func3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int ITERS = XLEN / UNROLL;
   localparam int CW    = $clog2(ITERS);
   localparam logic [CW-1:0]   CNT_LAST = CW'(ITERS - 1);
   localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t state_q, state_d;

   logic [CW-1:0]     cnt_q;
   logic [2:0]        func_q;
   logic              neg_q;
   logic [XLEN-1:0]   mcand_q, hi_q, lo_q;
   logic [XLEN-1:0]   hi_d, lo_d;
   logic [XLEN:0]     sum, sh;
   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0]   quo_s, rem_s, fin_val, fast_val;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic              accept, fast, is_div, a_signed, b_signed, a_neg, b_neg;
   logic              div_zero, div_ovf, neg_in;

   // Operand decode at acceptance: signedness, magnitudes and fast-path detection
   assign accept   = (state_q == IDLE) & start & ~flush;
   assign is_div   = func3[2];
   assign a_signed = is_div ? ~func3[0] : (func3 != 3'b011);
   assign b_signed = is_div ? ~func3[0] : ~func3[1];
   assign a_neg    = a_signed & op_a[XLEN-1];
   assign b_neg    = b_signed & op_b[XLEN-1];
   assign mag_a    = a_neg ? -op_a : op_a;
   assign mag_b    = b_neg ? -op_b : op_b;
   assign div_zero = is_div & (op_b == '0);
   assign div_ovf  = is_div & ~func3[0] & (op_a == MIN_INT) & (op_b == '1);
   assign fast     = div_zero | div_ovf;
   assign neg_in   = (is_div & func3[1]) ? a_neg : (a_neg ^ b_neg);

   // The pipeline must hold while a new op is requested outside DONE or one is running
   assign stall = (start & (state_q != DONE)) | (state_q == CALC);

   // Fast-path values: divide by zero and MIN_INT / -1
   always_comb begin
      fast_val = '0;
      if (div_zero)
         fast_val = func3[1] ? op_a : '1;
      else if (div_ovf)
         fast_val = func3[1] ? '0 : MIN_INT;
   end

   // UNROLL shift-add or restoring-divide steps applied to the {hi,lo} accumulator
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      sum  = '0;
      sh   = '0;
      for (int i = 0; i < UNROLL; i++) begin
         if (func_q[2]) begin
            sh   = {hi_d, lo_d[XLEN-1]};
            lo_d = {lo_d[XLEN-2:0], 1'b0};
            if (sh >= {1'b0, mcand_q}) begin
               hi_d    = sh[XLEN-1:0] - mcand_q;
               lo_d[0] = 1'b1;
            end else begin
               hi_d = sh[XLEN-1:0];
            end
         end else begin
            sum  = {1'b0, hi_d} + (lo_d[0] ? {1'b0, mcand_q} : '0);
            lo_d = {sum[0], lo_d[XLEN-1:1]};
            hi_d = sum[XLEN:1];
         end
      end
   end

   // Sign correction and selection of the architectural result
   always_comb begin
      prod   = {hi_d, lo_d};
      prod_s = neg_q ? -prod : prod;
      quo_s  = neg_q ? -lo_d : lo_d;
      rem_s  = neg_q ? -hi_d : hi_d;
      case (func_q)
         3'b000:                 fin_val = prod_s[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fin_val = prod_s[2*XLEN-1:XLEN];
         3'b100, 3'b101:         fin_val = quo_s;
         default:                fin_val = rem_s;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: accept in IDLE, iterate in CALC, single-cycle DONE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = fast ? DONE : CALC;
         CALC: begin
            if (flush)             state_d = IDLE;
            else if (cnt_q == '0)  state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath registers: latch operands on accept, iterate in CALC, commit result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         cnt_q   <= '0;
         func_q  <= '0;
         neg_q   <= 1'b0;
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         busy <= (state_d == CALC);
         done <= (state_d == DONE);
         if (accept) begin
            func_q  <= func3;
            neg_q   <= neg_in;
            mcand_q <= mag_b;
            hi_q    <= '0;
            lo_q    <= mag_a;
            cnt_q   <= CNT_LAST;
            if (fast) result <= fast_val;
         end else if ((state_q == CALC) && !flush) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == '0) result <= fin_val;
         end
      end
   end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Directed bench for rv_muldiv_unit: a 32-bit/UNROLL=1 instance and a
// 64-bit/UNROLL=4 instance, checked against hand-computed results and latencies.
module tb_rv_muldiv_unit;

   logic clk = 1'b0;
   logic rst;

   logic        start_32, flush_32;
   logic [2:0]  func3_32;
   logic [31:0] op_a_32, op_b_32;
   logic        stall_32, busy_32, done_32;
   logic [31:0] result_32;

   logic        start_64, flush_64;
   logic [2:0]  func3_64;
   logic [63:0] op_a_64, op_b_64;
   logic        stall_64, busy_64, done_64;
   logic [63:0] result_64;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   rv_muldiv_unit #(.XLEN(32), .UNROLL(1)) dut32 (
      .clk(clk), .rst(rst), .start(start_32), .func3(func3_32),
      .op_a(op_a_32), .op_b(op_b_32), .flush(flush_32),
      .stall(stall_32), .busy(busy_32), .done(done_32), .result(result_32)
   );

   rv_muldiv_unit #(.XLEN(64), .UNROLL(4)) dut64 (
      .clk(clk), .rst(rst), .start(start_64), .func3(func3_64),
      .op_a(op_a_64), .op_b(op_b_64), .flush(flush_64),
      .stall(stall_64), .busy(busy_64), .done(done_64), .result(result_64)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   // Compare one observed value with its expected value and report a mismatch
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Issue one op starting just after a rising edge, scramble the inputs after
   // the accept edge, and wait (bounded) for the done pulse
   task automatic applyStimulus(input bit wide, input logic [2:0] f,
                                input logic [63:0] a, input logic [63:0] b,
                                output int lat, output int scnt,
                                output logic busy1, output logic [63:0] res);
      lat = 0; scnt = 0; busy1 = 1'b0; res = '0;
      if (wide) begin
         start_64 = 1'b1; func3_64 = f; op_a_64 = a; op_b_64 = b;
      end else begin
         start_32 = 1'b1; func3_32 = f; op_a_32 = a[31:0]; op_b_32 = b[31:0];
      end
      @(negedge clk);
      if (wide ? stall_64 : stall_32) scnt++;
      @(posedge clk); #1;
      if (wide) begin
         start_64 = 1'b0; func3_64 = ~f; op_a_64 = ~a; op_b_64 = ~b;
      end else begin
         start_32 = 1'b0; func3_32 = ~f; op_a_32 = ~a[31:0]; op_b_32 = ~b[31:0];
      end
      while (lat < 100) begin
         lat++;
         @(negedge clk);
         if (lat == 1) busy1 = wide ? busy_64 : busy_32;
         if (wide ? stall_64 : stall_32) scnt++;
         if (wide ? done_64 : done_32) begin
            res = wide ? result_64 : {32'b0, result_32};
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int          lat, scnt;
      logic        busy1;
      logic [63:0] res;
      logic [31:0] last_res;

      rst = 1'b1;
      start_32 = 1'b0; flush_32 = 1'b0; func3_32 = '0; op_a_32 = '0; op_b_32 = '0;
      start_64 = 1'b0; flush_64 = 1'b0; func3_64 = '0; op_a_64 = '0; op_b_64 = '0;

      vecs.push_back('{"mul_7_m3",     3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33});
      vecs.push_back('{"mulh_min",     3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33});
      vecs.push_back('{"mulhu_min",    3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 33});
      vecs.push_back('{"mulhsu_ones",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33});
      vecs.push_back('{"mul_m1_m1",    3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33});
      vecs.push_back('{"mulh_m1_m1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33});
      vecs.push_back('{"div_m7_2",     3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33});
      vecs.push_back('{"rem_m7_2",     3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33});
      vecs.push_back('{"divu_100_7",   3'b101, 32'd100,      32'd7,        32'd14,       33});
      vecs.push_back('{"remu_100_7",   3'b111, 32'd100,      32'd7,        32'd2,        33});
      vecs.push_back('{"divu_min_m1",  3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33});
      vecs.push_back('{"div_by_zero",  3'b100, 32'h00000064, 32'h00000000, 32'hFFFFFFFF, 1});
      vecs.push_back('{"remu_by_zero", 3'b111, 32'h00000064, 32'h00000000, 32'h00000064, 1});
      vecs.push_back('{"rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});
      vecs.push_back('{"div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_busy",   busy_32,   0);
      checkOutput("rst_done",   done_32,   0);
      checkOutput("rst_result", result_32, 0);
      checkOutput("rst_stall",  stall_32,  0);
      checkOutput("rst_res64",  result_64, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      last_res = '0;
      foreach (vecs[i]) begin
         applyStimulus(1'b0, vecs[i].f, {32'b0, vecs[i].a}, {32'b0, vecs[i].b}, lat, scnt, busy1, res);
         checkOutput({vecs[i].tag, "_result"}, res, {32'b0, vecs[i].exp});
         checkOutput({vecs[i].tag, "_latency"}, lat, vecs[i].lat);
         checkOutput({vecs[i].tag, "_stall"}, scnt, vecs[i].lat);
         checkOutput({vecs[i].tag, "_busy1"}, busy1, (vecs[i].lat > 1) ? 1 : 0);
         checkOutput({vecs[i].tag, "_busy_after"}, busy_32, 0);
         checkOutput({vecs[i].tag, "_done_after"}, done_32, 0);
         last_res = vecs[i].exp;
      end

      // Flush while idle must block acceptance
      start_32 = 1'b1; flush_32 = 1'b1; func3_32 = 3'b000; op_a_32 = 32'd3; op_b_32 = 32'd5;
      @(posedge clk); #1;
      start_32 = 1'b0; flush_32 = 1'b0;
      checkOutput("idle_flush_busy", busy_32, 0);
      @(posedge clk); #1;
      checkOutput("idle_flush_done",   done_32,   0);
      checkOutput("idle_flush_result", result_32, {32'b0, last_res});

      // Flush at CALC cycle 10 of a DIVU aborts it without a done pulse
      start_32 = 1'b1; func3_32 = 3'b101; op_a_32 = 32'd100; op_b_32 = 32'd7;
      @(posedge clk); #1;
      start_32 = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      checkOutput("calc_busy_before_flush", busy_32, 1);
      flush_32 = 1'b1;
      @(posedge clk); #1;
      flush_32 = 1'b0;
      checkOutput("flush_busy",   busy_32,   0);
      checkOutput("flush_done",   done_32,   0);
      checkOutput("flush_stall",  stall_32,  0);
      checkOutput("flush_result", result_32, {32'b0, last_res});
      applyStimulus(1'b0, 3'b000, 64'd3, 64'd5, lat, scnt, busy1, res);
      checkOutput("post_flush_mul_result",  res, 64'd15);
      checkOutput("post_flush_mul_latency", lat, 33);

      // Reset at CALC cycle 5 clears outputs without waiting for a clock edge
      start_32 = 1'b1; func3_32 = 3'b101; op_a_32 = 32'd100; op_b_32 = 32'd7;
      @(posedge clk); #1;
      start_32 = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      checkOutput("calc_busy_before_rst", busy_32, 1);
      rst = 1'b1;
      #1;
      checkOutput("async_rst_busy",   busy_32,   0);
      checkOutput("async_rst_done",   done_32,   0);
      checkOutput("async_rst_result", result_32, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      // 64-bit instance, four bits per cycle
      applyStimulus(1'b1, 3'b000, 64'd1 << 40, 64'd1 << 20, lat, scnt, busy1, res);
      checkOutput("mul64_result",  res, 64'd1 << 60);
      checkOutput("mul64_latency", lat, 17);
      checkOutput("mul64_stall",   scnt, 17);
      applyStimulus(1'b1, 3'b101, 64'd1 << 60, 64'd1 << 20, lat, scnt, busy1, res);
      checkOutput("divu64_result",  res, 64'd1 << 40);
      checkOutput("divu64_latency", lat, 17);
      applyStimulus(1'b1, 3'b100, 64'hFFFFFFFFFFFFFF9C, 64'd7, lat, scnt, busy1, res);
      checkOutput("div64_result", res, 64'hFFFFFFFFFFFFFFF2);
      applyStimulus(1'b1, 3'b110, 64'hFFFFFFFFFFFFFF9C, 64'd7, lat, scnt, busy1, res);
      checkOutput("rem64_result", res, 64'hFFFFFFFFFFFFFFFE);
      applyStimulus(1'b1, 3'b100, 64'd100, 64'd0, lat, scnt, busy1, res);
      checkOutput("div64_zero_result",  res, 64'hFFFFFFFFFFFFFFFF);
      checkOutput("div64_zero_latency", lat, 1);
      checkOutput("div64_busy_after",   busy_64, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
